// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential shift-add-3 (double-dabble) binary-to-BCD converter. It feeds
//   the bcd0..bcd3 inputs of the 4-digit 7-segment scanner, so its digit
//   outputs are held and change only on the valid pulse.
//
// Parameters
//   IN_W      binary input width, 4..16
//   SATURATE  1: over-range input (> 9999) shows 9999; 0: shows value mod 10000
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   start      in   conversion request, accepted only while ready=1
//   bin        in   unsigned value, sampled on the accepting edge
//   hex_mode   in   (only with BCD_HEX_BYPASS_EN) show bin as raw hex nibbles
//   ready      out  converter idle, can accept start
//   valid      out  one-cycle pulse: bcd0..bcd3/ovf just updated
//   bcd0..3    out  units .. thousands digit (held)
//   ovf        out  last converted value was > 9999 (held)
//
// Configuration macro
//   BCD_HEX_BYPASS_EN  adds hex_mode; a hex request loads the nibbles of bin
//                      on the accepting edge, without entering SHIFT.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready=1, waiting for start
// SHIFT | one add-3/shift iteration per cycle, IN_W cycles in total

module bin_to_bcd_seq #(
    parameter int IN_W     = 14,
    parameter bit SATURATE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
`ifdef BCD_HEX_BYPASS_EN
    input  logic            hex_mode,
`endif
    output logic            ready,
    output logic            valid,
    output logic [3:0]      bcd0,
    output logic [3:0]      bcd1,
    output logic [3:0]      bcd2,
    output logic [3:0]      bcd3,
    output logic            ovf
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_n;
    logic [IN_W-1:0] sh_q, sh_n;
    logic [19:0]     scr_q, scr_n;
    logic [4:0]      cnt_q, cnt_n;
    logic            ovfp_q, ovfp_n;
    logic [15:0]     dig_q, dig_n;
    logic            ovf_n;
    logic            valid_n;

    logic [19:0]      adj;
    logic [19+IN_W:0] cat;

    // Add-3 correction on every scratch digit, then one combined left shift.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < 5; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
        end
    end

    assign cat = {adj, sh_q} << 1;

    always_comb begin
        state_n = state_q;
        sh_n    = sh_q;
        scr_n   = scr_q;
        cnt_n   = cnt_q;
        ovfp_n  = ovfp_q;
        dig_n   = dig_q;
        ovf_n   = ovf;
        valid_n = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
`ifdef BCD_HEX_BYPASS_EN
                    if (hex_mode) begin
                        dig_n   = 16'(bin);
                        ovf_n   = 1'b0;
                        valid_n = 1'b1;
                    end else begin
`endif
                        sh_n    = bin;
                        scr_n   = '0;
                        ovfp_n  = (32'(bin) > 32'd9999);
                        cnt_n   = 5'(IN_W);
                        state_n = SHIFT;
`ifdef BCD_HEX_BYPASS_EN
                    end
`endif
                end
            end
            SHIFT: begin
                scr_n = cat[19+IN_W:IN_W];
                sh_n  = cat[IN_W-1:0];
                cnt_n = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    // Last iteration: publish the result straight from the
                    // combinational step; the fifth digit is dropped.
                    state_n = IDLE;
                    valid_n = 1'b1;
                    ovf_n   = ovfp_q;
                    if (SATURATE && ovfp_q)
                        dig_n = 16'h9999;
                    else
                        dig_n = cat[IN_W+15:IN_W];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            ovfp_q  <= 1'b0;
            dig_q   <= '0;
            ovf     <= 1'b0;
            valid   <= 1'b0;
        end else begin
            state_q <= state_n;
            sh_q    <= sh_n;
            scr_q   <= scr_n;
            cnt_q   <= cnt_n;
            ovfp_q  <= ovfp_n;
            dig_q   <= dig_n;
            ovf     <= ovf_n;
            valid   <= valid_n;
        end
    end

    assign bcd0 = dig_q[3:0];
    assign bcd1 = dig_q[7:4];
    assign bcd2 = dig_q[11:8];
    assign bcd3 = dig_q[15:12];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Drives two converters (saturating and modulo) with the same stimulus and
//   checks results from a scoreboard of expected digits and arrival cycles.

module tb_bin_to_bcd_seq;

    localparam int IN_W = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [IN_W-1:0] bin = '0;
`ifdef BCD_HEX_BYPASS_EN
    logic            hex_mode = 1'b0;
`endif
    logic            ready, valid, ovf;
    logic [3:0]      bcd0, bcd1, bcd2, bcd3;
    logic            ready_m, valid_m, ovf_m;
    logic [3:0]      m0, m1, m2, m3;

    bin_to_bcd_seq #(.IN_W(IN_W), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
`ifdef BCD_HEX_BYPASS_EN
        .hex_mode(hex_mode),
`endif
        .ready(ready), .valid(valid),
        .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .ovf(ovf)
    );

    bin_to_bcd_seq #(.IN_W(IN_W), .SATURATE(1'b0)) dut_m (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
`ifdef BCD_HEX_BYPASS_EN
        .hex_mode(hex_mode),
`endif
        .ready(ready_m), .valid(valid_m),
        .bcd0(m0), .bcd1(m1), .bcd2(m2), .bcd3(m3), .ovf(ovf_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] sat;
        logic [16:0] md;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] hold_sat = '0;
    logic [16:0] hold_md  = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [16:0] model(input int v, input bit sat);
        int m;
        logic ov;
        ov = (v > 9999);
        if (sat && ov) return {ov, 16'h9999};
        m = v % 10000;
        return {ov, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Scoreboard checker: every valid pops one expectation; between valids the
    // held outputs must not move.
    always @(negedge clk) begin
        if (rst) begin
            if (valid) begin
                vectors++;
                assert (q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL spurious_valid: observed valid=1 expected no pending result (cycle %0d)", cyc);
                end
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    check("result_sat", 32'({ovf, bcd3, bcd2, bcd1, bcd0}), 32'(e.sat));
                    check("result_mod", 32'({ovf_m, m3, m2, m1, m0}), 32'(e.md));
                    check("latency", cyc, e.due);
                    check("ready_with_valid", 32'(ready), 32'd1);
                    check("valid_mod", 32'(valid_m), 32'd1);
                    hold_sat = e.sat;
                    hold_md  = e.md;
                end
            end else begin
                check("hold_sat", 32'({ovf, bcd3, bcd2, bcd1, bcd0}), 32'(hold_sat));
                check("hold_mod", 32'({ovf_m, m3, m2, m1, m0}), 32'(hold_md));
                check("valid_mod_low", 32'(valid_m), 32'd0);
            end
        end
    end

    task automatic push(input int v, input int due);
        exp_t e;
        e.sat = model(v, 1'b1);
        e.md  = model(v, 1'b0);
        e.due = due;
        q.push_back(e);
    endtask

    task automatic launch(input int v);
        @(negedge clk);
        start = 1'b1;
        bin   = IN_W'(v);
        push(v, cyc + 1 + IN_W);
        @(negedge clk);
        start = 1'b0;
        check("ready_busy", 32'(ready), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wait_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic wait_cycle(input int target);
        int n = 0;
        while (cyc != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_cycle", cyc, target);
    endtask

    initial begin
        int due1, due2;
        #1;
        check("reset_outputs", 32'({ovf, bcd3, bcd2, bcd1, bcd0}), 32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_valid", 32'(valid), 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        launch(1234);
        wait_done();
        launch(0);
        wait_done();
        launch(9999);
        wait_done();
        launch(10000);
        wait_done();
        launch(16383);
        wait_done();

        // Back-to-back with start held high; bin changes mid-conversion.
        @(negedge clk);
        start = 1'b1;
        bin   = IN_W'(42);
        due1  = cyc + 1 + IN_W;
        push(42, due1);
        @(negedge clk);
        check("ready_busy_b2b", 32'(ready), 32'd0);
        wait_cycle(due1);
        bin  = IN_W'(57);
        due2 = cyc + 1 + IN_W;
        push(57, due2);
        repeat (5) @(negedge clk);
        bin = IN_W'(999);
        wait_cycle(due2);
        start = 1'b0;
        wait_done();

        // Reset during SHIFT cycle 7 aborts the conversion.
        launch(777);
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_outputs", 32'({ovf, bcd3, bcd2, bcd1, bcd0}), 32'd0);
        check("abort_outputs_mod", 32'({ovf_m, m3, m2, m1, m0}), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        q.delete();
        hold_sat = '0;
        hold_md  = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        launch(5);
        wait_done();

`ifdef BCD_HEX_BYPASS_EN
        begin
            exp_t e;
            @(negedge clk);
            start    = 1'b1;
            hex_mode = 1'b1;
            bin      = IN_W'(16'h3ABC);
            e.sat    = {1'b0, 16'h3ABC};
            e.md     = {1'b0, 16'h3ABC};
            e.due    = cyc + 1;
            q.push_back(e);
            @(negedge clk);
            start    = 1'b0;
            hex_mode = 1'b0;
            wait_done();
        end
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
